// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-stage bundle linking the PC, instruction memory and decode.
interface instr_fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  i_pc;
  logic               o_pc_advance;
  logic               i_flush;
  logic               o_imem_req;
  logic [ADDR_W-1:0]  o_imem_addr;
  logic               i_imem_rvalid;
  logic [INSTR_W-1:0] i_imem_rdata;
  logic [INSTR_W-1:0] o_instr;
  logic [ADDR_W-1:0]  o_instr_pc;
  logic               o_instr_valid;
  logic               i_instr_ready;
  logic               o_fetch_err;
  logic               o_fetch_err_cause;
  modport master (
    input  i_pc, i_flush, i_imem_rvalid, i_imem_rdata, i_instr_ready,
    output o_pc_advance, o_imem_req, o_imem_addr, o_instr, o_instr_pc, o_instr_valid,
           o_fetch_err, o_fetch_err_cause
  );
  modport slave (
    output i_pc, i_flush, i_imem_rvalid, i_imem_rdata, i_instr_ready,
    input  o_pc_advance, o_imem_req, o_imem_addr, o_instr, o_instr_pc, o_instr_valid,
           o_fetch_err, o_fetch_err_cause
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: one imem read per PC, buffered to decode under valid/ready, with flush/timeout/misalign handling.
module instr_fetch_unit #(
  parameter int ADDR_W   = 32,
  parameter int INSTR_W  = 32,
  parameter int MAX_WAIT = 15
) (
  input logic clk,
  input logic rst_n,
  instr_fetch_if.master bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [2:0] {IDLE, REQ, HOLD, DROP, ERR} state_t;
  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt, w_cnt_next, w_cnt_inc;
  logic [ADDR_W-1:0]  r_req_pc, w_addr;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_cause, w_req, w_adv, w_to;
  assign w_cnt_inc = (r_cnt == CW'(MAX_WAIT)) ? r_cnt : r_cnt + 1'b1;
  assign w_to      = r_cnt >= CW'(MAX_WAIT - 1);
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_req      = 1'b0;
    w_adv      = 1'b0;
    w_addr     = r_req_pc;
    case (r_state)
      IDLE: begin
        w_addr = bus.i_pc;
        if (!bus.i_flush) begin
          if (bus.i_pc[1:0] != 2'b00) w_next = ERR;
          else begin
            w_req      = 1'b1;
            w_cnt_next = '0;
            w_next     = bus.i_imem_rvalid ? HOLD : REQ;
          end
        end
      end
      REQ: begin
        w_req = 1'b1;
        if (bus.i_imem_rvalid) w_next = bus.i_flush ? IDLE : HOLD;
        else begin
          w_cnt_next = w_cnt_inc;
          w_next     = w_to ? ERR : bus.i_flush ? DROP : REQ;
        end
      end
      HOLD: begin
        w_adv  = bus.i_instr_ready & ~bus.i_flush;
        w_next = (bus.i_flush | bus.i_instr_ready) ? IDLE : HOLD;
      end
      DROP: begin
        w_req = 1'b1;
        if (bus.i_imem_rvalid) w_next = IDLE;
        else begin
          w_cnt_next = w_cnt_inc;
          w_next     = w_to ? ERR : DROP;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_req_pc   <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_cause    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == IDLE && w_req) r_req_pc <= bus.i_pc;
      if (w_next == HOLD && r_state != HOLD) begin
        r_instr    <= bus.i_imem_rdata;
        r_instr_pc <= (r_state == IDLE) ? bus.i_pc : r_req_pc;
      end
      if (w_next == ERR && r_state != ERR) r_cause <= (r_state == IDLE);
    end
  end
  // IDLE drives the bus combinationally from pc_i, so gate it while reset is held
  assign bus.o_imem_req        = rst_n & w_req;
  assign bus.o_imem_addr       = rst_n ? w_addr : '0;
  assign bus.o_pc_advance      = w_adv;
  assign bus.o_instr           = r_instr;
  assign bus.o_instr_pc        = r_instr_pc;
  assign bus.o_instr_valid     = r_state == HOLD;
  assign bus.o_fetch_err       = r_state == ERR;
  assign bus.o_fetch_err_cause = r_cause;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table plus hand-written corner sequences, checked against a scoreboard.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  instr_fetch_if bus();
  instr_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {logic [31:0] pc; int waits; bit zw; logic [31:0] data; int rdy;} vec_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} exp_t;
  vec_t vecs[6];
  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    bus.i_pc = '0;
    bus.i_flush = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata = '0;
    bus.i_instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", bus.o_instr_valid, 0);
    chk("rst_req", bus.o_imem_req, 0);
    chk("rst_addr", bus.o_imem_addr, 0);
    chk("rst_adv", bus.o_pc_advance, 0);
    chk("rst_err", {bus.o_fetch_err, bus.o_fetch_err_cause}, 0);
    chk("rst_instr", {bus.o_instr, bus.o_instr_pc}, 0);
    rst_n = 1'b1;
  endtask
  // Entered in the IDLE cycle (just after a negedge); leaves the DUT in IDLE just after a negedge
  task automatic fetch(input vec_t v);
    exp_t e;
    bus.i_pc = v.pc;
    bus.i_imem_rvalid = v.zw;
    bus.i_imem_rdata = v.data;
    bus.i_instr_ready = 1'b0;
    #1;
    chk("idle_req", bus.o_imem_req, 1);
    chk("idle_addr", bus.o_imem_addr, v.pc);
    sb.push_back('{v.data, v.pc});
    if (!v.zw) begin
      for (int i = 0; i < v.waits; i++) begin
        @(negedge clk);
        bus.i_imem_rvalid = 1'b0;
        #1;
        chk("wait_req", {bus.o_imem_req, bus.o_instr_valid}, 2'b10);
        chk("wait_addr", bus.o_imem_addr, v.pc);
      end
      @(negedge clk);
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata = v.data;
      #1 chk("resp_req", bus.o_imem_req, 1);
    end
    @(negedge clk);
    bus.i_imem_rvalid = 1'b0;
    for (int k = 0; k < v.rdy; k++) begin
      #1;
      chk("hold_valid", {bus.o_instr_valid, bus.o_imem_req, bus.o_pc_advance}, 3'b100);
      chk("hold_instr", bus.o_instr, v.data);
      @(negedge clk);
    end
    bus.i_instr_ready = 1'b1;
    #1;
    chk("hs_valid", bus.o_instr_valid, 1);
    chk("hs_adv", bus.o_pc_advance, 1);
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sb_empty: handshake with no expected entry");
    end else begin
      e = sb.pop_front();
      chk("sb_instr", bus.o_instr, e.instr);
      chk("sb_pc", bus.o_instr_pc, e.pc);
    end
    @(negedge clk);
    bus.i_instr_ready = 1'b0;
    #1 chk("post_hs", {bus.o_instr_valid, bus.o_pc_advance}, 2'b00);
  endtask
  initial begin
    vecs[0] = '{32'h0000_0000, 2, 1'b0, 32'h0000_0013, 0};
    vecs[1] = '{32'h0000_0004, 2, 1'b0, 32'h0010_0093, 5};
    vecs[2] = '{32'h0000_0008, 0, 1'b0, 32'h0020_8133, 1};
    vecs[3] = '{32'h0000_000C, 0, 1'b1, 32'hFEDC_BA98, 0};
    vecs[4] = '{32'h0000_0010, 14, 1'b0, 32'hCAFE_F00D, 2};
    vecs[5] = '{32'hFFFF_FFFC, 3, 1'b0, 32'h1234_5678, 0};
    reset_dut();
    foreach (vecs[i]) fetch(vecs[i]);
    // flush during the first REQ wait cycle: late response must be discarded
    bus.i_pc = 32'h40;
    #1 chk("fl_addr0", bus.o_imem_addr, 32'h40);
    @(negedge clk);
    bus.i_flush = 1'b1;
    #1 chk("fl_req", bus.o_imem_req, 1);
    @(negedge clk);
    bus.i_flush = 1'b0;
    bus.i_pc = 32'h100;
    #1;
    chk("drop_req", {bus.o_imem_req, bus.o_instr_valid}, 2'b10);
    chk("drop_addr", bus.o_imem_addr, 32'h40);
    @(negedge clk);
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata = 32'hDEAD_BEEF;
    #1 chk("drop_resp", bus.o_instr_valid, 0);
    @(negedge clk);
    bus.i_imem_rvalid = 1'b0;
    #1;
    chk("fl_idle", {bus.o_instr_valid, bus.o_imem_req}, 2'b01);
    chk("fl_addr", bus.o_imem_addr, 32'h100);
    fetch('{32'h100, 1, 1'b0, 32'h0000_0517, 0});
    // flush in HOLD with ready high: buffer dropped, no advance
    bus.i_pc = 32'h200;
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.i_imem_rvalid = 1'b0;
    bus.i_flush = 1'b1;
    bus.i_instr_ready = 1'b1;
    #1 chk("hfl", {bus.o_instr_valid, bus.o_pc_advance}, 2'b10);
    @(negedge clk);
    bus.i_flush = 1'b0;
    bus.i_instr_ready = 1'b0;
    bus.i_pc = 32'h204;
    #1 chk("hfl_idle", {bus.o_instr_valid, bus.o_imem_req}, 2'b01);
    fetch('{32'h204, 0, 1'b1, 32'h0000_0297, 1});
    // zero-wait fetch, then async reset in the middle of HOLD
    bus.i_pc = 32'h500;
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus.i_imem_rvalid = 1'b0;
    #1;
    chk("zw_valid", bus.o_instr_valid, 1);
    chk("zw_instr", {bus.o_instr, bus.o_instr_pc}, {32'h5555_AAAA, 32'h500});
    rst_n = 1'b0;
    #1 chk("arst", {bus.o_instr_valid, bus.o_imem_req, bus.o_instr}, 0);
    reset_dut();
    // misaligned PC
    bus.i_pc = 32'h102;
    #1 chk("mis_req", bus.o_imem_req, 0);
    @(negedge clk);
    bus.i_pc = 32'h0;
    #1 chk("mis_err", {bus.o_fetch_err, bus.o_fetch_err_cause, bus.o_imem_req}, 3'b110);
    @(negedge clk);
    #1 chk("mis_stick", {bus.o_fetch_err, bus.o_imem_req}, 2'b10);
    reset_dut();
    // response never arrives: 15 wait cycles then timeout error
    bus.i_pc = 32'h600;
    #1 chk("to_idle", bus.o_imem_req, 1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #1 chk("to_wait", {bus.o_imem_req, bus.o_fetch_err}, 2'b10);
    end
    @(negedge clk);
    #1 chk("to_err", {bus.o_fetch_err, bus.o_fetch_err_cause, bus.o_imem_req}, 3'b100);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    #1 chk("to_stick", {bus.o_fetch_err, bus.o_fetch_err_cause, bus.o_imem_req}, 3'b100);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
